// File: rtl/filter_unpad.sv
// rtl/filter_unpad.sv - strips zero-padding from the filter's raster output
// and queues the interior pixels with their coordinates in a small FIFO.
module filter_unpad #(
  parameter int width      = 320,
  parameter int height     = 240,
  parameter int kernelSize = 3,
  parameter int dataWidth  = 24,
  parameter int fifoDepth  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 newFrame,
  input  logic                 iValid,
  input  logic [dataWidth-1:0] iData,
  input  logic                 iReady,
  output logic                 oValid,
  output logic [dataWidth-1:0] oData,
  output logic [15:0]          oX,
  output logic [15:0]          oY,
  output logic                 oDone,
  output logic                 oOverflow,
  output logic                 oBusy
);

  localparam int b    = (kernelSize - 1) / 2;
  localparam int pw   = width + 2 * b;
  localparam int ph   = height + 2 * b;
  localparam int ptrW = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
  localparam bit noPad = (b == 0);

  localparam logic [15:0] colLast  = 16'(pw - 1);
  localparam logic [15:0] rowLast  = 16'(ph - 1);
  localparam logic [15:0] topLast  = 16'(b - 1);
  localparam logic [15:0] bodyLast = 16'(b + height - 1);
  localparam logic [15:0] bOff     = 16'(b);
  localparam logic [15:0] widthC   = 16'(width);
  localparam logic [15:0] heightC  = 16'(height);
  localparam logic [15:0] xLast    = 16'(width - 1);
  localparam logic [15:0] yLast    = 16'(height - 1);
  localparam logic [ptrW:0] depthC = (ptrW + 1)'(fifoDepth);

  typedef enum logic [1:0] {IDLE, PAD_TOP, BODY, PAD_BOTTOM} state_t;

  state_t              state, curState, nextState;
  logic [15:0]         col, row, curCol, curRow, tagX, tagY;
  logic [ptrW-1:0]     wrPtr, rdPtr, curWr, curRd;
  logic [ptrW:0]       count, curCount;
  logic                endOfRow, interior, isLast, pop, full, push, drop;

  logic [dataWidth-1:0] memData [fifoDepth];
  logic [15:0]          memX    [fifoDepth];
  logic [15:0]          memY    [fifoDepth];
  logic                 memLast [fifoDepth];

  // newFrame acts as a same-cycle clear, so a concurrent beat sees a fresh frame.
  always_comb begin
    curState  = newFrame ? IDLE : state;
    curCol    = newFrame ? 16'd0 : col;
    curRow    = newFrame ? 16'd0 : row;
    curWr     = newFrame ? '0 : wrPtr;
    curRd     = newFrame ? '0 : rdPtr;
    curCount  = newFrame ? '0 : count;
    // Unsigned wrap makes padding columns/rows before b land far out of range.
    tagX      = curCol - bOff;
    tagY      = curRow - bOff;
    endOfRow  = (curCol == colLast);
    interior  = iValid && (tagX < widthC) && (tagY < heightC);
    isLast    = (tagX == xLast) && (tagY == yLast);
    pop       = (count != '0) && iReady && !newFrame;
    full      = (curCount == depthC);
    push      = interior && (!full || pop);
    drop      = interior && full && !pop;
    nextState = curState;
    if (iValid) begin
      unique case (curState)
        IDLE:       nextState = noPad ? ((endOfRow && curRow == rowLast) ? IDLE : BODY)
                                      : PAD_TOP;
        PAD_TOP:    if (endOfRow && curRow == topLast) nextState = BODY;
        BODY:       if (endOfRow && curRow == bodyLast) nextState = noPad ? IDLE : PAD_BOTTOM;
        PAD_BOTTOM: if (endOfRow && curRow == rowLast) nextState = IDLE;
        default:    nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      col       <= 16'd0;
      row       <= 16'd0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      oDone     <= 1'b0;
      oOverflow <= 1'b0;
    end else begin
      state <= nextState;
      if (iValid) begin
        if (endOfRow) begin
          col <= 16'd0;
          row <= (curRow == rowLast) ? 16'd0 : curRow + 16'd1;
        end else begin
          col <= curCol + 16'd1;
          row <= curRow;
        end
      end else begin
        col <= curCol;
        row <= curRow;
      end
      wrPtr <= push ? curWr + ptrW'(1) : curWr;
      rdPtr <= pop ? curRd + ptrW'(1) : curRd;
      unique case ({push, pop})
        2'b10:   count <= curCount + (ptrW + 1)'(1);
        2'b01:   count <= curCount - (ptrW + 1)'(1);
        default: count <= curCount;
      endcase
      oDone     <= pop && memLast[rdPtr];
      oOverflow <= (oOverflow && !newFrame) || drop;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      memData[curWr] <= iData;
      memX[curWr]    <= tagX;
      memY[curWr]    <= tagY;
      memLast[curWr] <= isLast;
    end
  end

  assign oValid = (count != '0);
  assign oData  = oValid ? memData[rdPtr] : '0;
  assign oX     = oValid ? memX[rdPtr] : 16'd0;
  assign oY     = oValid ? memY[rdPtr] : 16'd0;
  assign oBusy  = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_filter_unpad.sv
// tb/tb_filter_unpad.sv - directed bench for filter_unpad with a 3x3 kernel
// instance (4x3 interior) and a pass-through kernelSize=1 instance.
module tb_filter_unpad;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstA, nfA, ivA, irA, ovA, doneA, ofA, busyA;
  logic [23:0] idA, odA;
  logic [15:0] oxA, oyA;
  logic        rstB, nfB, ivB, irB, ovB, doneB, ofB, busyB;
  logic [23:0] idB, odB;
  logic [15:0] oxB, oyB;

  filter_unpad #(.width(4), .height(3), .kernelSize(3), .dataWidth(24), .fifoDepth(4)) dutA (
    .clk(clk), .reset(rstA), .newFrame(nfA), .iValid(ivA), .iData(idA), .iReady(irA),
    .oValid(ovA), .oData(odA), .oX(oxA), .oY(oyA), .oDone(doneA), .oOverflow(ofA), .oBusy(busyA)
  );

  filter_unpad #(.width(4), .height(3), .kernelSize(1), .dataWidth(24), .fifoDepth(4)) dutB (
    .clk(clk), .reset(rstB), .newFrame(nfB), .iValid(ivB), .iData(idB), .iReady(irB),
    .oValid(ovB), .oData(odB), .oX(oxB), .oY(oyB), .oDone(doneB), .oOverflow(ofB), .oBusy(busyB)
  );

  int nAsserts = 0;
  int nFail = 0;
  int cyc = 0;
  logic [55:0] qA[$];
  logic [55:0] qB[$];
  int doneCntA = 0, doneCntB = 0, doneCycA = 0, lastPopCycA = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ovA && irA && !nfA && !rstA) begin
      qA.push_back({odA, oxA, oyA});
      lastPopCycA = cyc;
    end
    if (doneA) begin
      doneCntA++;
      doneCycA = cyc;
    end
    if (ovB && irB && !nfB && !rstB) qB.push_back({odB, oxB, oyB});
    if (doneB) doneCntB++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drvA(input logic v, input int d, input logic r, input logic nf);
    ivA = v; idA = 24'(d); irA = r; nfA = nf;
    @(posedge clk); #1;
  endtask

  task automatic drvB(input logic v, input int d, input logic r);
    ivB = v; idB = 24'(d); irB = r;
    @(posedge clk); #1;
  endtask

  // 6-column padded raster: interior (x,y) sits at beat (y+1)*6 + (x+1).
  function automatic logic [55:0] expA(input int base, input int k);
    int x, y;
    x = k % 4;
    y = k / 4;
    return {24'(base + (y + 1) * 6 + x + 1), 16'(x), 16'(y)};
  endfunction

  function automatic logic [55:0] qAt(input int k, input logic isB);
    if (isB) return (k < qB.size()) ? qB[k] : '1;
    return (k < qA.size()) ? qA[k] : '1;
  endfunction

  task automatic clearMon();
    qA.delete(); qB.delete();
    doneCntA = 0; doneCntB = 0; doneCycA = 0; lastPopCycA = 0;
  endtask

  initial begin
    rstA = 1; nfA = 0; ivA = 0; idA = 0; irA = 0;
    rstB = 1; nfB = 0; ivB = 0; idB = 0; irB = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_oValid", ovA, 0);
    chk("rst_oBusy", busyA, 0);
    rstA = 0; rstB = 0;
    @(posedge clk); #1;
    chk("rst_oValid2", ovA, 0);
    chk("rst_oDone", doneA, 0);
    chk("rst_oOverflow", ofA, 0);
    chk("rst_oBusy2", busyA, 0);
    chk("rst_oData", odA, 0);
    chk("rst_oX", oxA, 0);
    chk("rst_oY", oyA, 0);

    // Frame with continuous downstream ready
    clearMon();
    for (int i = 0; i < 30; i++) drvA(1, i, 1, 0);
    repeat (4) drvA(0, 0, 1, 0);
    chk("t1_count", qA.size(), 12);
    for (int k = 0; k < 12; k++) chk($sformatf("t1_out%0d", k), qAt(k, 0), expA(0, k));
    chk("t1_first", qAt(0, 0), {24'd7, 16'd0, 16'd0});
    chk("t1_last", qAt(11, 0), {24'd22, 16'd3, 16'd2});
    chk("t1_doneCnt", doneCntA, 1);
    chk("t1_doneTiming", doneCycA, lastPopCycA + 1);
    chk("t1_overflow", ofA, 0);
    chk("t1_busy", busyA, 0);

    // Downstream stalled: FIFO fills with the first four, the rest drop
    clearMon();
    for (int i = 0; i < 30; i++) drvA(1, i, 0, 0);
    chk("t2_oValid", ovA, 1);
    chk("t2_headData", odA, 7);
    chk("t2_headX", oxA, 0);
    chk("t2_overflow", ofA, 1);
    chk("t2_busy", busyA, 1);
    chk("t2_noPop", qA.size(), 0);
    repeat (6) drvA(0, 0, 1, 0);
    chk("t2_drained", qA.size(), 4);
    for (int k = 0; k < 4; k++) chk($sformatf("t2_out%0d", k), qAt(k, 0), expA(0, k));
    chk("t2_noDone", doneCntA, 0);
    chk("t2_overflowSticky", ofA, 1);
    chk("t2_busyEnd", busyA, 0);
    drvA(0, 0, 0, 1);
    chk("t2_nfClearsOverflow", ofA, 0);

    // Ready toggling every cycle; FIFO reaches full with simultaneous push/pop
    clearMon();
    for (int i = 0; i < 30; i++) drvA(1, i, (i % 2) == 0, 0);
    for (int j = 0; j < 12; j++) drvA(0, 0, (j % 2) == 0, 0);
    chk("t3_count", qA.size(), 12);
    for (int k = 0; k < 12; k++) chk($sformatf("t3_out%0d", k), qAt(k, 0), expA(0, k));
    chk("t3_overflow", ofA, 0);
    chk("t3_doneCnt", doneCntA, 1);

    // Two frames back-to-back
    clearMon();
    for (int i = 0; i < 60; i++) drvA(1, i, 1, 0);
    repeat (4) drvA(0, 0, 1, 0);
    chk("t4_count", qA.size(), 24);
    for (int k = 0; k < 24; k++)
      chk($sformatf("t4_out%0d", k), qAt(k, 0), expA((k < 12) ? 0 : 30, k % 12));
    chk("t4_f2first", qAt(12, 0), {24'd37, 16'd0, 16'd0});
    chk("t4_doneCnt", doneCntA, 2);

    // newFrame at beat 15 with a full FIFO and overflow set
    for (int i = 0; i < 15; i++) drvA(1, i, 0, 0);
    chk("t5_preOverflow", ofA, 1);
    chk("t5_preValid", ovA, 1);
    clearMon();
    drvA(1, 100, 1, 1);
    chk("t5_fifoEmptied", ovA, 0);
    chk("t5_overflowCleared", ofA, 0);
    for (int k = 1; k <= 30; k++) drvA(1, 100 + k, 1, 0);
    drvA(0, 0, 1, 0);
    chk("t5_nextFrameBusy", busyA, 1);
    repeat (3) drvA(0, 0, 1, 0);
    chk("t5_count", qA.size(), 12);
    for (int k = 0; k < 12; k++) chk($sformatf("t5_out%0d", k), qAt(k, 0), expA(100, k));
    chk("t5_doneCnt", doneCntA, 1);
    chk("t5_overflow", ofA, 0);

    // kernelSize=1: everything is interior
    for (int i = 0; i < 12; i++) drvB(1, i, 1);
    repeat (3) drvB(0, 0, 1);
    chk("t6_count", qB.size(), 12);
    for (int k = 0; k < 12; k++)
      chk($sformatf("t6_out%0d", k), qAt(k, 1), {24'(k), 16'(k % 4), 16'(k / 4)});
    chk("t6_doneCnt", doneCntB, 1);
    chk("t6_busyIdle", busyB, 0);
    chk("t6_overflow", ofB, 0);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 3; i++) drvB(1, 40 + i, 0);
    chk("t6_preValid", ovB, 1);
    chk("t6_preBusy", busyB, 1);
    #2 rstB = 1;
    #1;
    chk("t6_rstValid", ovB, 0);
    chk("t6_rstBusy", busyB, 0);
    chk("t6_rstData", odB, 0);
    @(negedge clk);
    rstB = 0;
    drvB(1, 50, 1);
    chk("t6_afterRstValid", ovB, 1);
    chk("t6_afterRstHead", {odB, oxB, oyB}, {24'd50, 16'd0, 16'd0});
    drvB(0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
